seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the 4-digit multiplexed seven-segment driver.
- Samples the active-low Segment/AN scan bus and reconstructs the displayed 16-bit hex value, decimal points and blanking per digit.
- Decodes each segment pattern back to a nibble and publishes a coherent frame once all four digits have been captured.
- Used as an on-board loopback monitor and as a checker in display regression benches.

---
 rtl/seg_scan_decoder.sv | 87 ++++++++
 tb/tb_seg_scan_decoder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers hex digits, points, blanking and glyph errors from a multiplexed active-low 7-seg scan bus
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_W = 11
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [7:0]  Segment,
  input  logic [3:0]  AN,
  output logic [15:0] Hexs,
  output logic [3:0]  Points,
  output logic [3:0]  Blank,
  output logic [3:0]  Err,
  output logic        frame_valid
);
  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);
  localparam logic [111:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  logic [7:0] s_seg, q_seg;
  logic [3:0] s_an, q_an;
  logic [CNT_W-1:0] cnt;
  logic [3:0] seen, sel;
  logic [15:0] st_hex;
  logic [3:0] st_pt, st_bl, st_er;
  logic [6:0] pat;
  logic [3:0] nib;
  logic [1:0] k;
  logic hit, blank, legal, same, commit;
  always_comb begin
    pat = ~s_seg[6:0];
    hit = 1'b0;
    nib = 4'h0;
    for (int i = 0; i < 16; i++)
      if (GLYPHS[7*i +: 7] == pat) begin
        hit = 1'b1;
        nib = 4'(i);
      end
  end
  assign blank  = pat == 7'h00;
  assign sel    = ~s_an;
  assign legal  = s_an == 4'hE || s_an == 4'hD || s_an == 4'hB || s_an == 4'h7;
  assign k      = !s_an[0] ? 2'd0 : !s_an[1] ? 2'd1 : !s_an[2] ? 2'd2 : 2'd3;
  assign same   = s_an == q_an && s_seg == q_seg;
  // saturation at STABLE makes the first arrival the only commit of a dwell
  assign commit = legal && same && cnt == STABLE - 1'b1;
  always_ff @(posedge clk) begin
    if (RST) begin
      s_seg <= 8'hFF;
      q_seg <= 8'hFF;
      s_an <= 4'hF;
      q_an <= 4'hF;
      cnt <= '0;
      seen <= 4'h0;
      st_hex <= 16'h0;
      st_pt <= 4'h0;
      st_bl <= 4'h0;
      st_er <= 4'h0;
      Hexs <= 16'h0;
      Points <= 4'h0;
      Blank <= 4'h0;
      Err <= 4'h0;
      frame_valid <= 1'b0;
    end else begin
      s_seg <= Segment;
      s_an <= AN;
      q_seg <= s_seg;
      q_an <= s_an;
      cnt <= !legal ? '0 : !same ? CNT_W'(1) : cnt == STABLE ? cnt : cnt + 1'b1;
      frame_valid <= &seen;
      if (&seen) begin
        Hexs <= st_hex;
        Points <= st_pt;
        Blank <= st_bl;
        Err <= st_er;
      end
      seen <= (&seen ? 4'h0 : seen) | (commit ? sel : 4'h0);
      if (commit) begin
        st_hex[4*k +: 4] <= hit ? nib : 4'h0;
        st_pt[k] <= ~s_seg[7];
        st_bl[k] <= blank;
        st_er[k] <= !hit && !blank;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans checked every cycle against a run-length model of the scan bus
module tb_seg_scan_decoder;
  localparam int S = 1024;
  localparam int H = 1100;
  logic clk = 1'b0;
  logic RST;
  logic [7:0] Segment;
  logic [3:0] AN;
  logic [15:0] Hexs;
  logic [3:0] Points, Blank, Err;
  logic frame_valid;
  int checks = 0;
  int errors = 0;
  int frames = 0;
  logic [6:0] gt [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] m_hex, ms_hex;
  logic [3:0] m_pt, m_bl, m_er, ms_pt, ms_bl, ms_er, m_seen;
  logic m_fv;
  logic [11:0] m_prev;
  int m_run;

  seg_scan_decoder #(.STABLE_CYCLES(S), .CNT_W(11)) dut (
    .clk(clk), .RST(RST), .Segment(Segment), .AN(AN), .Hexs(Hexs),
    .Points(Points), .Blank(Blank), .Err(Err), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  // model: a legal bus value seen on S+1 consecutive edges commits its digit once
  always @(posedge clk) begin
    if (RST) begin
      m_run = 0;
      m_prev = 12'h0;
      m_seen = 4'h0;
      {m_hex, m_pt, m_bl, m_er, m_fv} = '0;
      {ms_hex, ms_pt, ms_bl, ms_er} = '0;
    end else begin
      m_fv = m_seen == 4'hF;
      if (m_fv) begin
        {m_hex, m_pt, m_bl, m_er} = {ms_hex, ms_pt, ms_bl, ms_er};
        m_seen = 4'h0;
      end
      m_run = (m_run > 0 && {AN, Segment} == m_prev) ? (m_run > S + 5 ? m_run : m_run + 1) : 1;
      m_prev = {AN, Segment};
      if (m_run == S + 1) begin
        for (int d = 0; d < 4; d++)
          if (AN == ~(4'b1 << d)) begin
            int v;
            v = -1;
            for (int g = 0; g < 16; g++) if (~Segment[6:0] == gt[g]) v = g;
            ms_hex[4*d +: 4] = v < 0 ? 4'h0 : 4'(v);
            ms_pt[d] = ~Segment[7];
            ms_bl[d] = Segment[6:0] == 7'h7F;
            ms_er[d] = v < 0 && Segment[6:0] != 7'h7F;
            m_seen[d] = 1'b1;
          end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({Hexs, Points, Blank, Err, frame_valid} !== {m_hex, m_pt, m_bl, m_er, m_fv}) begin
      errors++;
      $display("FAIL cycle_compare t=%0t got hex=%h pt=%b bl=%b er=%b fv=%b want hex=%h pt=%b bl=%b er=%b fv=%b",
               $time, Hexs, Points, Blank, Err, frame_valid, m_hex, m_pt, m_bl, m_er, m_fv);
    end
    if (frame_valid === 1'b1) frames++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [7:0] s, input int n);
    AN = a;
    Segment = s;
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] sg(input int v, input bit p);
    logic [6:0] g;
    g = gt[v];
    return {~p, ~g};
  endfunction

  initial begin
    RST = 1'b1;
    AN = 4'h0;
    Segment = 8'h12;
    @(negedge clk);
    repeat (3) @(negedge clk);
    RST = 1'b0;
    hold(4'hF, 8'hFF, 5);
    chk("reset_hexs", 32'(Hexs), 32'h0);
    chk("reset_frames", frames, 0);
    // normal scan 1234, point on digit 2
    hold(4'hE, sg(4, 0), H);
    hold(4'hD, sg(3, 0), H);
    hold(4'hB, sg(2, 1), H);
    hold(4'h7, sg(1, 0), H);
    hold(4'hF, 8'hFF, 10);
    chk("normal_frames", frames, 1);
    chk("normal_hexs", 32'(Hexs), 32'h1234);
    chk("normal_points", 32'(Points), 32'h4);
    chk("normal_blank_err", 32'({Blank, Err}), 32'h0);
    // glitched digit 1 never commits until the glitches stop
    for (int i = 0; i < 4; i++) begin
      hold(4'hD, sg(6, 0), 499);
      hold(4'hD, ~sg(6, 0), 1);
    end
    hold(4'hE, sg(5, 0), H);
    hold(4'hB, sg(7, 0), H);
    hold(4'h7, sg(8, 0), H);
    chk("glitch_no_frame", frames, 1);
    hold(4'hD, sg(6, 0), H);
    hold(4'hF, 8'hFF, 10);
    chk("glitch_frames", frames, 2);
    chk("glitch_hexs", 32'(Hexs), 32'h8765);
    // blank digit 3, unknown glyph on digit 0
    hold(4'hE, {1'b1, ~7'h01}, H);
    hold(4'hD, sg(9, 0), H);
    hold(4'hB, sg(10, 0), H);
    hold(4'h7, 8'hFF, H);
    hold(4'hF, 8'hFF, 10);
    chk("be_hexs", 32'(Hexs), 32'h0A90);
    chk("be_blank", 32'(Blank), 32'h8);
    chk("be_err", 32'(Err), 32'h1);
    // illegal selects interleaved with legal digits
    hold(4'hE, sg(12, 0), H);
    hold(4'h0, sg(12, 0), H);
    hold(4'hD, sg(13, 0), H);
    hold(4'hF, sg(1, 0), H);
    hold(4'hB, sg(14, 0), H);
    hold(4'h0, sg(3, 1), H);
    hold(4'h7, sg(15, 0), H);
    hold(4'hF, 8'hFF, 10);
    chk("illegal_frames", frames, 4);
    chk("illegal_hexs", 32'(Hexs), 32'hFEDC);
    // reset after three commits, then BEEF starting from digit 3
    hold(4'hE, sg(1, 0), H);
    hold(4'hD, sg(2, 0), H);
    hold(4'hB, sg(3, 0), H);
    RST = 1'b1;
    hold(4'hB, sg(3, 0), 3);
    RST = 1'b0;
    chk("midreset_hexs", 32'(Hexs), 32'h0);
    hold(4'h7, sg(11, 0), H);
    chk("midreset_no_frame", frames, 4);
    hold(4'hE, sg(15, 0), H);
    hold(4'hD, sg(14, 0), H);
    hold(4'hB, sg(14, 0), H);
    hold(4'hF, 8'hFF, 10);
    chk("beef_frames", frames, 5);
    chk("beef_hexs", 32'(Hexs), 32'hBEEF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
